// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: FIFO of register-file writes drained one per cycle, with newest-first bypass lookup.
// Define WB_BYPASS_EN to build the lookup comparators; otherwise LookupHit/LookupData are tied to 0.
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [ADDR_W-1:0]        InReg,
  input  logic [DATA_W-1:0]        InData,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        WriteRegister,
  output logic [DATA_W-1:0]        WriteData,
  input  logic [ADDR_W-1:0]        LookupReg,
  output logic                     LookupHit,
  output logic [DATA_W-1:0]        LookupData,
  output logic [$clog2(DEPTH):0]   Count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  logic [ADDR_W-1:0] regQ [DEPTH];
  logic [DATA_W-1:0] dataQ [DEPTH];
  logic [PW-1:0] head, tail;
  logic push, pop;

  assign InReady = Rst_n && (Count < Full);
  assign pop = Count != '0;
  // Writes to x0 complete the handshake but are dropped.
  assign push = InValid && InReady && (InReg != '0);

  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      head <= '0;
      tail <= '0;
      Count <= '0;
      RegWrite <= 1'b0;
      WriteRegister <= '0;
      WriteData <= '0;
    end else begin
      RegWrite <= pop;
      if (pop) begin
        WriteRegister <= regQ[head];
        WriteData <= dataQ[head];
        head <= head + 1'b1;
      end
      if (push) tail <= tail + 1'b1;
      Count <= Count + CW'(push) - CW'(pop);
    end

  always_ff @(posedge Clk)
    if (push) begin
      regQ[tail] <= InReg;
      dataQ[tail] <= InData;
    end

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so the youngest match overrides; output stage is lowest priority.
  always_comb begin
    LookupHit = 1'b0;
    LookupData = '0;
    if (RegWrite && WriteRegister == LookupReg) begin
      LookupHit = 1'b1;
      LookupData = WriteData;
    end
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) < Count && regQ[head + PW'(i)] == LookupReg) begin
        LookupHit = 1'b1;
        LookupData = dataQ[head + PW'(i)];
      end
    if (LookupReg == '0) begin
      LookupHit = 1'b0;
      LookupData = '0;
    end
  end
`else
  logic unusedLookup;
  assign unusedLookup = ^LookupReg;
  assign LookupHit = 1'b0;
  assign LookupData = '0;
`endif
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb_regfile_writeback_queue: randomized scoreboard bench against a queue-level model of the writeback FIFO.
module tb_regfile_writeback_queue;
  localparam int DEPTH = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } entry_t;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic InValid = 1'b0;
  logic [ADDR_W-1:0] InReg = '0;
  logic [DATA_W-1:0] InData = '0;
  logic [ADDR_W-1:0] LookupReg = '0;
  logic InReady, RegWrite, LookupHit;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData, LookupData;
  logic [$clog2(DEPTH):0] Count;

  int checks = 0;
  int failures = 0;

  entry_t pend[$];
  entry_t expq[$];
  entry_t outE;
  bit outV = 0;
  bit acc = 0;

  regfile_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReady(InReady), .InReg(InReg),
    .InData(InData), .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .LookupReg(LookupReg), .LookupHit(LookupHit), .LookupData(LookupData), .Count(Count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the queue holds after each edge.
  always @(posedge Clk)
    if (Rst_n) begin
      acc = InValid && pend.size() < DEPTH;
      if (pend.size() > 0) begin
        outE = pend.pop_front();
        outV = 1;
      end else outV = 0;
      if (acc && InReg != '0) begin
        pend.push_back('{InReg, InData});
        expq.push_back('{InReg, InData});
      end
    end

  always @(negedge Rst_n) begin
    pend.delete();
    expq.delete();
    outV = 0;
  end

  // Monitor: compares DUT against the model away from the active edge.
  always @(negedge Clk) begin
    entry_t e;
    bit hit;
    logic [DATA_W-1:0] ld;
    check("count", 64'(Count), 64'(pend.size()));
    check("in_ready", 64'(InReady), 64'(Rst_n && pend.size() < DEPTH));
    check("reg_write", 64'(RegWrite), 64'(outV));
    if (RegWrite) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: reg %0d data 0x%0h with nothing pending", WriteRegister, WriteData);
      end else begin
        e = expq.pop_front();
        check("write_register", 64'(WriteRegister), 64'(e.r));
        check("write_data", 64'(WriteData), 64'(e.d));
      end
    end
    hit = 0;
    ld = '0;
`ifdef WB_BYPASS_EN
    if (LookupReg != '0) begin
      for (int i = pend.size() - 1; i >= 0 && !hit; i--)
        if (pend[i].r == LookupReg) begin
          hit = 1;
          ld = pend[i].d;
        end
      if (!hit && outV && outE.r == LookupReg) begin
        hit = 1;
        ld = outE.d;
      end
    end
`endif
    check("lookup_hit", 64'(LookupHit), 64'(hit));
    check("lookup_data", 64'(LookupData), 64'(ld));
  end

  task automatic step(input bit v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] lr);
    InValid = v;
    InReg = r;
    InData = d;
    LookupReg = lr;
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] lr);
    for (int k = 0; k < 20; k++) begin
      step(1, r, d, lr);
      if (acc) begin
        InValid = 0;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL push_timeout: reg %0d never accepted", r);
    InValid = 0;
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1;
    @(posedge Clk);
    #1;
    push(5'd8, 32'h0000_00AA, 5'd8);
    repeat (3) step(0, 0, 0, 5'd8);
    for (int i = 9; i <= 13; i++) push(5'(i), 32'(i * 3), 5'(i));
    repeat (3) step(0, 0, 0, 5'd12);
    push(5'd0, 32'hFFFF_FFFF, 5'd0);
    repeat (3) step(0, 0, 0, 5'd0);
    push(5'd16, 32'h1, 5'd16);
    push(5'd16, 32'h2, 5'd16);
    repeat (4) step(0, 0, 0, 5'd16);
    push(5'd3, 32'h33, 5'd3);
    push(5'd4, 32'h44, 5'd3);
    #2;
    Rst_n = 0;
    #1;
    check("rst_count", 64'(Count), 64'd0);
    check("rst_regwrite", 64'(RegWrite), 64'd0);
    check("rst_inready", 64'(InReady), 64'd0);
    InValid = 0;
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1;
    @(posedge Clk);
    #1;
    repeat (4) step(0, 0, 0, 5'd3);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)));
    repeat (6) step(0, 0, 0, 0);
    check("drained", 64'(expq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
